// File: rtl/uart_pkg.sv
// Shared definitions for the 8051-style UART transmit/receive blocks:
// frame state encodings, SCON mode/bit positions and bus addresses.
package uart_pkg;

  // Frame states. ST_BIT9 is the ninth-bit slot that the transmit side calls "crc".
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_BIT9  = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  // SCON.SM serial modes
  localparam logic [1:0] SM_MODE0 = 2'b00;
  localparam logic [1:0] SM_MODE1 = 2'b01;
  localparam logic [1:0] SM_MODE2 = 2'b10;
  localparam logic [1:0] SM_MODE3 = 2'b11;

  // SCON bit positions
  localparam int SCON_SM_MSB = 7;
  localparam int SCON_SM_LSB = 6;
  localparam int SCON_SM2    = 5;
  localparam int SCON_REN    = 4;
  localparam int SCON_TB8    = 3;
  localparam int SCON_RB8    = 2;
  localparam int SCON_TI     = 1;
  localparam int SCON_RI     = 0;

  // Transmit shift register and receive buffer share one address;
  // write selects the transmitter, read selects the receiver.
  localparam logic [7:0] ADDR_TSHIFT = 8'h98;
  localparam logic [7:0] ADDR_RBUF   = 8'h98;

  // div_clk ticks per bit
  localparam int OVS_DFLT = 16;

  // 2-of-3 vote used for noise-tolerant bit resolution
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Receive-side bit sampler: rxd synchroniser, 16x tick counter and
// mid-bit resolution. Build macro UART_RX_MAJORITY_EN selects a 2-of-3
// vote of ticks 7/8/9; otherwise the tick-8 sample alone is used. Both
// resolve on the pulse that advances the counter to tick 9.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVS = OVS_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic div_clk,
  input  logic rxd,
  input  logic cnt_clr,
  output logic rxd_s,
  output logic rxd_s_dly,
  output logic bit_valid,
  output logic bit_val,
  output logic bit_wrap
);

  localparam int TW = $clog2(OVS);
  // Counter values just before the pulses that reach ticks 7, 8, 9
  localparam logic [TW-1:0] T_TO7  = TW'(OVS / 2 - 2);
  localparam logic [TW-1:0] T_TO8  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_TO9  = TW'(OVS / 2);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);

  logic          sync1_q, sync1_d;
  logic          rxd_s_q, rxd_s_d;
  logic          rxd_dly_q, rxd_dly_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          s8_q, s8_d;
`ifdef UART_RX_MAJORITY_EN
  logic          s7_q, s7_d;
`endif

  // Next-state for synchroniser, tick counter and mid-bit samples
  always_comb begin
    sync1_d   = rxd;
    rxd_s_d   = sync1_q;
    rxd_dly_d = rxd_s_q;
    tick_d    = tick_q;
    s8_d      = s8_q;
    if (cnt_clr) begin
      tick_d = '0;
    end else if (div_clk) begin
      tick_d = (tick_q == T_LAST) ? '0 : tick_q + TW'(1);
    end
    if (div_clk && (tick_q == T_TO8)) s8_d = rxd_s_q;
`ifdef UART_RX_MAJORITY_EN
    s7_d = s7_q;
    if (div_clk && (tick_q == T_TO7)) s7_d = rxd_s_q;
`endif
  end

  // State registers; the synchroniser idles at the line's mark level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      rxd_s_q   <= 1'b1;
      rxd_dly_q <= 1'b1;
      tick_q    <= '0;
      s8_q      <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      s7_q      <= 1'b1;
`endif
    end else begin
      sync1_q   <= sync1_d;
      rxd_s_q   <= rxd_s_d;
      rxd_dly_q <= rxd_dly_d;
      tick_q    <= tick_d;
      s8_q      <= s8_d;
`ifdef UART_RX_MAJORITY_EN
      s7_q      <= s7_d;
`endif
    end
  end

  assign rxd_s     = rxd_s_q;
  assign rxd_s_dly = rxd_dly_q;
  assign bit_valid = div_clk && !cnt_clr && (tick_q == T_TO9);
  assign bit_wrap  = div_clk && !cnt_clr && (tick_q == T_LAST);
`ifdef UART_RX_MAJORITY_EN
  // Tick-9 sample is the live synchronised value on the resolving pulse
  assign bit_val   = maj3(s7_q, s8_q, rxd_s_q);
`else
  assign bit_val   = s8_q;
`endif

endmodule

// File: rtl/uart_receive.sv
// 8051-style UART receive stage for modes 1/2/3. Deserialises rxd,
// applies the SCON RI/SM2 load rules, pulses ri for one clk on a load and
// keeps a sticky frame-error flag cleared by a buffer read.
// Build macro UART_RX_MAJORITY_EN (in uart_rx_sampler) enables 2-of-3 voting.
module uart_receive
  import uart_pkg::*;
#(
  parameter logic [7:0] RBUF_ADDR = ADDR_RBUF,
  parameter int         OVS       = OVS_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       div_clk,
  input  logic       rxd,
  input  logic [7:0] scon,
  input  logic [7:0] ab,
  input  logic       rdn,
  output logic [7:0] db_r,
  output logic       ri,
  output logic       rb8,
  output logic       fe,
  output logic       rx_busy
);

  uart_state_e state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        bit9_q, bit9_d;
  logic [1:0]  sm_q, sm_d;
  logic        sm2_q, sm2_d;
  logic [7:0]  rbuf_q, rbuf_d;
  logic        rb8_q, rb8_d;
  logic        ri_q, ri_d;
  logic        fe_q, fe_d;

  logic        rxd_s, rxd_s_dly, bit_valid, bit_val, bit_wrap;
  logic        cnt_clr, flag_bit, start_edge, rd_hit, ren;
  logic [1:0]  scon_sm;
  logic        unused_scon;

  assign scon_sm     = scon[SCON_SM_MSB:SCON_SM_LSB];
  assign ren         = scon[SCON_REN];
  assign start_edge  = rxd_s_dly && !rxd_s;
  assign rd_hit      = !rdn && (ab == RBUF_ADDR);
  // TB8/RB8/TI belong to the transmit and SCON logic
  assign unused_scon = ^scon[SCON_TB8:SCON_TI];

  uart_rx_sampler #(.OVS(OVS)) u_sampler (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_clk   (div_clk),
    .rxd       (rxd),
    .cnt_clr   (cnt_clr),
    .rxd_s     (rxd_s),
    .rxd_s_dly (rxd_s_dly),
    .bit_valid (bit_valid),
    .bit_val   (bit_val),
    .bit_wrap  (bit_wrap)
  );

  // Frame FSM next-state, buffer load rules and fe set/clear
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    bit9_d    = bit9_q;
    sm_d      = sm_q;
    sm2_d     = sm2_q;
    rbuf_d    = rbuf_q;
    rb8_d     = rb8_q;
    fe_d      = fe_q;
    ri_d      = 1'b0;
    cnt_clr   = 1'b0;
    // Stop bit in mode 1, ninth bit in modes 2/3
    flag_bit  = sm_q[1] ? bit9_q : bit_val;

    // A read clears fe; a coincident stop-bit error below re-sets it
    if (rd_hit) fe_d = 1'b0;

    if ((state_q != ST_IDLE) && !ren) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ren && (scon_sm != SM_MODE0) && start_edge) begin
            state_d   = ST_START;
            cnt_clr   = 1'b1;
            sm_d      = scon_sm;
            sm2_d     = scon[SCON_SM2];
            shift_d   = 8'h00;
            bit9_d    = 1'b0;
            bit_cnt_d = 3'd0;
          end
        end
        ST_START: begin
          // A high mid-start sample is a glitch, not a frame
          if (bit_valid && bit_val) state_d = ST_IDLE;
          else if (bit_wrap)        state_d = ST_DATA;
        end
        ST_DATA: begin
          if (bit_valid) begin
            shift_d   = {bit_val, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = sm_q[1] ? ST_BIT9 : ST_STOP;
          end
        end
        ST_BIT9: begin
          if (bit_valid) begin
            bit9_d  = bit_val;
            state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_valid) begin
            if (!bit_val) fe_d = 1'b1;
            if (!scon[SCON_RI] && (!sm2_q || flag_bit)) begin
              rbuf_d = shift_q;
              rb8_d  = flag_bit;
              ri_d   = 1'b1;
            end
            // Leaving at mid-stop lets the next start edge be seen early
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Frame state, receive buffer and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      bit9_q    <= 1'b0;
      sm_q      <= SM_MODE0;
      sm2_q     <= 1'b0;
      rbuf_q    <= 8'h00;
      rb8_q     <= 1'b0;
      ri_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      bit9_q    <= bit9_d;
      sm_q      <= sm_d;
      sm2_q     <= sm2_d;
      rbuf_q    <= rbuf_d;
      rb8_q     <= rb8_d;
      ri_q      <= ri_d;
      fe_q      <= fe_d;
    end
  end

  assign db_r    = rd_hit ? rbuf_q : 8'h00;
  assign ri      = ri_q;
  assign rb8     = rb8_q;
  assign fe      = fe_q;
  assign rx_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive: frames are driven tick-aligned on rxd, expected
// loads are queued at drive time and popped when ri fires.
`timescale 1ns/1ps
module tb_uart_receive;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       div_clk = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] scon = 8'h00;
  logic [7:0] ab = 8'h00;
  logic       rdn = 1'b1;
  logic [7:0] db_r;
  logic       ri, rb8, fe, rx_busy;

  uart_receive dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .div_clk (div_clk),
    .rxd     (rxd),
    .scon    (scon),
    .ab      (ab),
    .rdn     (rdn),
    .db_r    (db_r),
    .ri      (ri),
    .rb8     (rb8),
    .fe      (fe),
    .rx_busy (rx_busy)
  );

  always #5 clk = ~clk;

  // div_clk: one-clk pulse every 4 clks
  logic [1:0] div_cnt = 2'd0;
  always @(posedge clk) begin
    div_cnt <= div_cnt + 2'd1;
    div_clk <= (div_cnt == 2'd3);
  end

  int pulses = 0;
  always @(posedge clk) if (div_clk) pulses <= pulses + 1;

  typedef struct {
    logic [7:0] data;
    logic       rb8;
    logic       fe;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_total = 0;
  int         n_bad = 0;
  int         start_mark = 0;
  logic       prev_ri = 1'b0;
  logic [7:0] exp_rbuf = 8'h00;
  logic       fe_model = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // ri monitor: pop the scoreboard and check flags and latency
  always @(negedge clk) begin
    if (ri) begin
      chk("ri_one_clk", {31'd0, prev_ri}, 32'd0);
      if (sb.size() == 0) begin
        chk("ri_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rb8_at_ri", {31'd0, rb8}, {31'd0, mon_e.rb8});
        chk("fe_at_ri", {31'd0, fe}, {31'd0, mon_e.fe});
        chk("ri_latency", pulses - start_mark, mon_e.lat);
      end
    end
    prev_ri <= ri;
  end

  task automatic wait_ticks(input int n);
    int target;
    target = pulses + n;
    while (pulses < target) @(negedge clk);
  endtask

  task automatic bus_read(input string tag, input logic [7:0] want);
    @(negedge clk);
    ab  = 8'h98;
    rdn = 1'b0;
    #1 chk(tag, {24'd0, db_r}, {24'd0, want});
    @(negedge clk);
    rdn = 1'b1;
    ab  = 8'h00;
    fe_model = 1'b0;
  endtask

  // Drive one frame with the current scon; queue an expectation if it should load
  task automatic send_frame(input logic [7:0] d, input logic has9, input logic b9,
                            input logic stopv);
    exp_t e;
    logic flag, load;
    flag = has9 ? b9 : stopv;
    load = scon[4] && (scon[7:6] != 2'b00) && !scon[0] && (!scon[5] || flag);
    fe_model = fe_model | !stopv;
    if (load) begin
      e.data = d;
      e.rb8  = flag;
      e.fe   = fe_model;
      e.lat  = has9 ? 169 : 153;
      sb.push_back(e);
      exp_rbuf = d;
    end
    wait_ticks(1);
    start_mark = pulses;
    rxd = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_ticks(16);
    end
    if (has9) begin
      rxd = b9;
      wait_ticks(16);
    end
    rxd = stopv;
    wait_ticks(16);
    rxd = 1'b1;
    wait_ticks(16);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    ab = 8'h98; rdn = 1'b0;
    #1;
    chk("rst_db_r", {24'd0, db_r}, 32'h00);
    chk("rst_ri", {31'd0, ri}, 32'd0);
    chk("rst_rb8", {31'd0, rb8}, 32'd0);
    chk("rst_fe", {31'd0, fe}, 32'd0);
    chk("rst_busy", {31'd0, rx_busy}, 32'd0);
    rdn = 1'b1; ab = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(4);

    // Mode 1, SM2=0: 0xA5, stop=1
    scon = 8'h50;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    chk("m1_rb8", {31'd0, rb8}, 32'd1);
    chk("m1_fe", {31'd0, fe}, 32'd0);
    bus_read("m1_db_r", exp_rbuf);
    @(negedge clk);
    ab = 8'h99; rdn = 1'b0;
    #1 chk("db_other_addr", {24'd0, db_r}, 32'h00);
    ab = 8'h98; rdn = 1'b1;
    #1 chk("db_no_rdn", {24'd0, db_r}, 32'h00);
    ab = 8'h00;

    // Mode 3, SM2=1: ninth bit 0 rejected, ninth bit 1 accepted
    scon = 8'hF0;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    bus_read("m3_reject_db", exp_rbuf);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    chk("m3_rb8", {31'd0, rb8}, 32'd1);
    bus_read("m3_accept_db", exp_rbuf);

    // Start glitch of 4 ticks, then a good frame
    scon = 8'h50;
    wait_ticks(1);
    rxd = 1'b0;
    wait_ticks(2);
    chk("glitch_busy_hi", {31'd0, rx_busy}, 32'd1);
    wait_ticks(2);
    rxd = 1'b1;
    wait_ticks(12);
    chk("glitch_busy_lo", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    bus_read("after_glitch_db", exp_rbuf);

    // RI already set: no load
    scon = 8'h51;
    send_frame(8'h77, 1'b0, 1'b0, 1'b1);
    bus_read("ri_held_db", exp_rbuf);

    // Framing error: 0x0F, stop=0
    scon = 8'h50;
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
    chk("fe_set", {31'd0, fe}, 32'd1);
    chk("fe_rb8", {31'd0, rb8}, 32'd0);
    bus_read("fe_db_r", exp_rbuf);
    chk("fe_cleared", {31'd0, fe}, 32'd0);

    // REN dropped during data bit 4
    wait_ticks(1);
    rxd = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0];
      wait_ticks(16);
    end
    rxd = 1'b1;
    wait_ticks(8);
    chk("ren_busy_before", {31'd0, rx_busy}, 32'd1);
    scon = 8'h40;
    @(negedge clk);
    chk("ren_abort_busy", {31'd0, rx_busy}, 32'd0);
    wait_ticks(4);
    scon = 8'h50;
    wait_ticks(16);
    bus_read("ren_abort_db", exp_rbuf);

    // Mode 2, SM2=0: ninth bit 1, stop 0 -> loads with rb8=1 and fe=1
    scon = 8'h90;
    send_frame(8'hC3, 1'b1, 1'b1, 1'b0);
    chk("m2_rb8", {31'd0, rb8}, 32'd1);
    chk("m2_fe", {31'd0, fe}, 32'd1);

    // Reset mid-frame
    scon = 8'h50;
    wait_ticks(1);
    rxd = 1'b0;
    wait_ticks(40);
    rst_n = 1'b0;
    ab = 8'h98; rdn = 1'b0;
    #1;
    chk("midrst_db_r", {24'd0, db_r}, 32'h00);
    chk("midrst_rb8", {31'd0, rb8}, 32'd0);
    chk("midrst_fe", {31'd0, fe}, 32'd0);
    chk("midrst_ri", {31'd0, ri}, 32'd0);
    chk("midrst_busy", {31'd0, rx_busy}, 32'd0);
    rdn = 1'b1; ab = 8'h00;
    rxd = 1'b1;
    exp_rbuf = 8'h00;
    fe_model = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(4);

    // Recovery frame after reset
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    bus_read("recover_db", exp_rbuf);

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
